// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 FP32/FP16 divider: radix-2 restoring mantissa divide behind a start/busy/done handshake.
// Define FDIV_FTZ_EN to flush subnormal operands and tiny results to signed zero.
module fdiv_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        round_mode,
    input  logic        mode_fp,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    localparam int DIV_CYCLES = 27 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // Operand widened to FP32 range: exp is a biased FP32 exponent, mant carries the hidden bit.
    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [10:0] exp;
        logic [23:0] mant;
    } unpk_t;

    function automatic unpk_t unpack_op(input logic [31:0] op, input logic fp32);
        unpk_t       u;
        logic [7:0]  e;
        logic [22:0] f;
        logic [10:0] bias;
`ifndef FDIV_FTZ_EN
        logic [23:0] raw;
        logic [10:0] eraw;
        int          lz;
`endif
        if (fp32) begin
            u.sign = op[31];
            e      = op[30:23];
            f      = op[22:0];
            bias   = 11'd0;
            u.nan  = (&op[30:23]) && (|f);
            u.inf  = (&op[30:23]) && !(|f);
        end else begin
            u.sign = op[15];
            e      = {3'b000, op[14:10]};
            f      = {op[9:0], 13'd0};
            bias   = 11'd112;
            u.nan  = (&op[14:10]) && (|f);
            u.inf  = (&op[14:10]) && !(|f);
        end
`ifdef FDIV_FTZ_EN
        u.zero = (e == 8'd0);
        u.exp  = {3'b000, e} + bias;
        u.mant = {1'b1, f};
`else
        u.zero = (e == 8'd0) && (f == 23'd0);
        raw    = {(e != 8'd0), f};
        eraw   = ((e != 8'd0) ? {3'b000, e} : 11'd1) + bias;
        lz     = 0;
        for (int i = 0; i < 24; i++) begin
            if (raw[i]) lz = 23 - i;
        end
        u.mant = raw << lz;
        u.exp  = eraw - 11'(lz);
`endif
        return u;
    endfunction

    function automatic logic [31:0] pack_inf(input logic s, input logic fp32);
        return fp32 ? {s, 8'hFF, 23'd0} : {16'd0, s, 5'h1F, 10'd0};
    endfunction

    function automatic logic [31:0] pack_zero(input logic s, input logic fp32);
        return fp32 ? {s, 31'd0} : {16'd0, s, 15'd0};
    endfunction

    // Right shift that folds every discarded bit into a sticky bit (LSB of the return value).
    function automatic logic [27:0] shr_sticky(input logic [26:0] v, input logic [10:0] sh);
        logic [26:0] mask;
        if (sh >= 11'd27) return {27'd0, |v};
        mask = (27'd1 << sh) - 27'd1;
        return {v >> sh, |(v & mask)};
    endfunction

    // Mantissa sits in q[26:3] (FP16: q[13:3]); returns {result, flags}.
    function automatic logic [36:0] round_pack(input logic [26:0] q, input logic stk,
                                               input logic [10:0] e, input logic tiny,
                                               input logic s, input logic fp32, input logic rne);
        logic [23:0] mant;
        logic        g, r, st, inx, inc, carry, hid, ovf;
        logic [24:0] sum;
        logic [10:0] eo;
        logic [31:0] res;
        mant  = q[26:3];
        g     = q[2];
        r     = q[1];
        st    = q[0] | stk;
        inx   = g | r | st;
        inc   = rne & g & (r | st | mant[0]);
        sum   = {1'b0, mant} + {24'd0, inc};
        carry = fp32 ? sum[24] : sum[11];
        hid   = fp32 ? sum[23] : sum[10];
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        eo    = tiny ? {10'd0, hid} : e + {10'd0, carry};
        ovf   = fp32 ? (eo >= 11'd255) : (eo >= 11'd31);
        if (ovf)       res = pack_inf(s, fp32);
        else if (fp32) res = {s, eo[7:0], sum[22:0]};
        else           res = {16'd0, s, eo[4:0], sum[9:0]};
        return {res, 1'b0, ovf, tiny & inx, 1'b0, inx | ovf};
    endfunction

    state_t             state;
    logic [31:0]        a_q, b_q;
    logic               rne_q, fp32_q, sign_q;
    logic               spec_q, sticky_q, tiny_q;
    logic [31:0]        spec_res_q;
    logic [4:0]         spec_flg_q;
    logic signed [10:0] exp_q;
    logic [25:0]        rem_q, rem_n;
    logic [26:0]        quo_q, quo_n;
    logic [23:0]        div_q;
    logic [4:0]         cnt_q;

    unpk_t              ua, ub;
    logic [26:0]        nq;
    logic signed [10:0] ne, te;
    logic [10:0]        sh;
    logic [27:0]        shr;
    logic               n_ovf, n_tiny;
    logic [36:0]        rp;

    always_comb begin
        ua = unpack_op(a_q, fp32_q);
        ub = unpack_op(b_q, fp32_q);
    end

    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_n >= {2'b00, div_q}) begin
                rem_n = (rem_n - {2'b00, div_q}) << 1;
                quo_n = {quo_n[25:0], 1'b1};
            end else begin
                rem_n = rem_n << 1;
                quo_n = {quo_n[25:0], 1'b0};
            end
        end
    end

    // FP16 results are aligned 13 bits lower so rounding happens once, at the target precision.
    always_comb begin
        nq = quo_q;
        ne = exp_q;
        if (!quo_q[26]) begin
            nq = {quo_q[25:0], 1'b0};
            ne = exp_q - 11'sd1;
        end
        te     = fp32_q ? ne : ne - 11'sd112;
        n_ovf  = fp32_q ? (te >= 11'sd255) : (te >= 11'sd31);
        n_tiny = (te <= 11'sd0);
        sh     = fp32_q ? 11'd0 : 11'd13;
`ifndef FDIV_FTZ_EN
        if (n_tiny) sh = sh + (11'sd1 - te);
`endif
        shr = shr_sticky(nq, sh);
    end

    always_comb rp = round_pack(quo_q, sticky_q, exp_q, tiny_q, sign_q, fp32_q, rne_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            flags      <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rne_q      <= 1'b0;
            fp32_q     <= 1'b0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            sticky_q   <= 1'b0;
            tiny_q     <= 1'b0;
            spec_res_q <= 32'd0;
            spec_flg_q <= 5'd0;
            exp_q      <= 11'sd0;
            rem_q      <= 26'd0;
            quo_q      <= 27'd0;
            div_q      <= 24'd0;
            cnt_q      <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        rne_q  <= round_mode;
                        fp32_q <= mode_fp;
                        busy   <= 1'b1;
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    // Specials bypass the datapath and pass through ROUND unchanged.
                    sign_q <= ua.sign ^ ub.sign;
                    spec_q <= 1'b1;
                    state  <= S_ROUND;
                    if (ua.nan || ub.nan || (ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
                        spec_res_q <= fp32_q ? 32'h7FC0_0000 : 32'h0000_7E00;
                        spec_flg_q <= 5'b10000;
                    end else if (ub.zero) begin
                        spec_res_q <= pack_inf(ua.sign ^ ub.sign, fp32_q);
                        spec_flg_q <= 5'b00010;
                    end else if (ua.inf) begin
                        spec_res_q <= pack_inf(ua.sign ^ ub.sign, fp32_q);
                        spec_flg_q <= 5'b00000;
                    end else if (ub.inf || ua.zero) begin
                        spec_res_q <= pack_zero(ua.sign ^ ub.sign, fp32_q);
                        spec_flg_q <= 5'b00000;
                    end else begin
                        spec_q <= 1'b0;
                        exp_q  <= ua.exp - ub.exp + 11'd127;
                        rem_q  <= {2'b00, ua.mant};
                        div_q  <= ub.mant;
                        quo_q  <= 27'd0;
                        cnt_q  <= 5'(DIV_CYCLES - 1);
                        state  <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    if (cnt_q == 5'd0) state <= S_NORM;
                    else               cnt_q <= cnt_q - 5'd1;
                end
                S_NORM: begin
                    if (n_ovf) begin
                        spec_q     <= 1'b1;
                        spec_res_q <= pack_inf(sign_q, fp32_q);
                        spec_flg_q <= 5'b01001;
`ifdef FDIV_FTZ_EN
                    end else if (n_tiny) begin
                        spec_q     <= 1'b1;
                        spec_res_q <= pack_zero(sign_q, fp32_q);
                        spec_flg_q <= 5'b00101;
`endif
                    end else begin
                        quo_q    <= shr[27:1];
                        sticky_q <= shr[0] | (|rem_q);
                        exp_q    <= n_tiny ? 11'sd0 : te;
                        tiny_q   <= n_tiny;
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    result <= spec_q ? spec_res_q : rp[36:5];
                    flags  <= spec_q ? spec_flg_q : rp[4:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: arithmetic vectors, specials, range limits, handshake and reset.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        round_mode, mode_fp;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  flags;

    int errors = 0;
    int checks = 0;

    fdiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .round_mode(round_mode), .mode_fp(mode_fp), .busy(busy), .done(done),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation; at iteration pulse_at a second start with other operands is driven while busy.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic rm, input logic fp, input logic [31:0] er,
                         input logic [4:0] ef, input int elat, input int pulse_at);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; round_mode = rm; mode_fp = fp; start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (i == pulse_at) begin
                op_a = 32'h3F80_0000; op_b = 32'h4040_0000; round_mode = ~rm; mode_fp = ~fp;
            end
            if (i == 0) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " result"}, result, er);
        check({tag, " flags"}, 32'(flags), 32'(ef));
        check({tag, " busy@done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        int first_d, second_d;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; round_mode = 1'b1; mode_fp = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        do_op("fp32 6/2",      32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4040_0000, 5'b00000, 30, -1);
        do_op("fp32 1/3 rne",  32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b1, 32'h3EAA_AAAB, 5'b00001, 30, -1);
        do_op("fp32 1/3 trn",  32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b1, 32'h3EAA_AAAA, 5'b00001, 30, -1);
        do_op("x/0",           32'h3F80_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h7F80_0000, 5'b00010, 2, -1);
        do_op("0/0",           32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h7FC0_0000, 5'b10000, 2, -1);
        do_op("-1/inf",        32'hBF80_0000, 32'h7F80_0000, 1'b1, 1'b1, 32'h8000_0000, 5'b00000, 2, -1);
        do_op("fp16 1/2",      32'hDEAD_3C00, 32'hBEEF_4000, 1'b1, 1'b0, 32'h0000_3800, 5'b00000, 30, -1);
        do_op("fp16 ovf",      32'h0000_7BFF, 32'h0000_1400, 1'b1, 1'b0, 32'h0000_7C00, 5'b01001, 30, -1);
        do_op("fp32 ovf",      32'h7F00_0000, 32'h3E80_0000, 1'b1, 1'b1, 32'h7F80_0000, 5'b01001, 30, -1);
        do_op("tiny exact",    32'h0080_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h0040_0000, 5'b00000, 30, -1);
        do_op("tiny inexact",  32'h0080_0001, 32'h4000_0000, 1'b1, 1'b1, 32'h0040_0000, 5'b00101, 30, -1);
        do_op("sub in",        32'h0000_0001, 32'h3F00_0000, 1'b1, 1'b1, 32'h0000_0002, 5'b00000, 30, -1);
        do_op("sub to norm",   32'h00FF_FFFF, 32'h4000_0000, 1'b1, 1'b1, 32'h0080_0000, 5'b00101, 30, -1);

        // A start pulse while busy must neither disturb nor queue behind the running operation.
        do_op("start ignored", 32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4040_0000, 5'b00000, 30, 5);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no queued op", 32'(ndone), 32'd0);
        check("result held", result, 32'h4040_0000);

        // Start held high through DONE: the second request is taken on the following IDLE cycle.
        @(negedge clk);
        op_a = 32'h3F80_0000; op_b = 32'h0000_0000; round_mode = 1'b1; mode_fp = 1'b1; start = 1'b1;
        @(posedge clk);
        first_d = -1; second_d = -1; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) first_d = i;
                if (ndone == 2) second_d = i;
            end
        end
        check("b2b first done", 32'(first_d), 32'd2);
        check("b2b second done", 32'(second_d), 32'd6);
        check("b2b done count", 32'(ndone), 32'd2);

        // Reset in the middle of a divide aborts with outputs cleared and no done pulse.
        @(negedge clk);
        op_a = 32'h3F80_0000; op_b = 32'h4040_0000; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no done", 32'(ndone), 32'd0);

        do_op("after reset",   32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4040_0000, 5'b00000, 30, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
